// File: rtl/imm_decode_stage.sv
// ID-stage immediate generator: decodes the MIPS opcode into an extension
// mode and registers the immediate behind a 2-entry output/skid buffer.
package imm_decode_pkg;

    typedef enum logic [2:0] {
        MODE_NONE   = 3'd0,
        MODE_ZERO   = 3'd1,
        MODE_SIGN   = 3'd2,
        MODE_LUI    = 3'd3,
        MODE_BRANCH = 3'd4,
        MODE_JUMP   = 3'd5
    } imm_mode_e;

    typedef struct packed {
        logic [31:0] imm;
        imm_mode_e   mode;
        logic        illegal;
    } imm_res_t;

    localparam imm_res_t RES_RESET = '{
        imm:     32'h0,
        mode:    MODE_NONE,
        illegal: 1'b0
    };

endpackage

module imm_decode_stage
    import imm_decode_pkg::*;
#(
    parameter int unsigned BR_SHIFT    = 2,
    parameter logic [31:0] ILLEGAL_IMM = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_imm,
    output logic [2:0]  out_mode,
    output logic        out_illegal
);

    logic [5:0]  opcode;
    logic [15:0] imm16;
    logic [31:0] sext;

    logic is_zero;
    logic is_sign;
    logic is_lui;
    logic is_br;
    logic is_jmp;
    logic is_rtype;

    imm_res_t dec;

    assign opcode = in_instr[31:26];
    assign imm16  = in_instr[15:0];
    assign sext   = {{16{imm16[15]}}, imm16};

    always_comb begin
        is_zero  = opcode inside {6'h0C, 6'h0D, 6'h0E};
        is_sign  = opcode inside {[6'h08:6'h0B], 6'h20,
                                  6'h23, 6'h24, 6'h28, 6'h2B};
        is_lui   = (opcode == 6'h0F);
        is_br    = opcode inside {6'h01, [6'h04:6'h07]};
        is_jmp   = opcode inside {6'h02, 6'h03};
        is_rtype = (opcode == 6'h00);
    end

    // Anything outside the table falls through to the illegal default.
    always_comb begin
        dec = '{imm: ILLEGAL_IMM, mode: MODE_NONE, illegal: 1'b1};
        unique case (1'b1)
            is_zero: begin
                dec = '{imm: {16'h0, imm16},
                        mode: MODE_ZERO, illegal: 1'b0};
            end
            is_sign: begin
                dec = '{imm: sext,
                        mode: MODE_SIGN, illegal: 1'b0};
            end
            is_lui: begin
                dec = '{imm: {imm16, 16'h0},
                        mode: MODE_LUI, illegal: 1'b0};
            end
            is_br: begin
                dec = '{imm: sext << BR_SHIFT,
                        mode: MODE_BRANCH, illegal: 1'b0};
            end
            is_jmp: begin
                dec = '{imm: {4'h0, in_instr[25:0], 2'b00},
                        mode: MODE_JUMP, illegal: 1'b0};
            end
            is_rtype: begin
                dec = RES_RESET;
            end
            default: ;
        endcase
    end

    imm_res_t out_q;
    imm_res_t out_d;
    imm_res_t skid_q;
    imm_res_t skid_d;
    logic     out_valid_q;
    logic     out_valid_d;
    logic     skid_valid_q;
    logic     skid_valid_d;

    logic accept;
    logic out_xfer;

    // A flushed cycle never counts as an input transfer.
    assign accept   = in_valid & ~skid_valid_q & ~flush;
    assign out_xfer = out_valid_q & out_ready;

    always_comb begin
        out_d        = out_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        priority case (1'b1)
            flush: begin
                out_valid_d  = 1'b0;
                skid_valid_d = 1'b0;
            end
            skid_valid_q: begin
                if (out_xfer) begin
                    out_d        = skid_q;
                    skid_valid_d = 1'b0;
                end
            end
            accept: begin
                if (!out_valid_q || out_ready) begin
                    out_d       = dec;
                    out_valid_d = 1'b1;
                end else begin
                    skid_d       = dec;
                    skid_valid_d = 1'b1;
                end
            end
            out_xfer: begin
                out_valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q        <= RES_RESET;
            skid_q       <= RES_RESET;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign in_ready    = ~skid_valid_q;
    assign out_valid   = out_valid_q;
    assign out_imm     = out_q.imm;
    assign out_mode    = out_q.mode;
    assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Scoreboard bench for imm_decode_stage: directed cases plus random
// traffic checked against an opcode-table reference model.
module tb_imm_decode_stage;

    localparam int          BR_SHIFT    = 2;
    localparam logic [31:0] ILLEGAL_IMM = 32'h0;

    typedef struct {
        logic [31:0] imm;
        logic [2:0]  mode;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_imm;
    logic [2:0]  out_mode;
    logic        out_illegal;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    imm_decode_stage #(
        .BR_SHIFT    (BR_SHIFT),
        .ILLEGAL_IMM (ILLEGAL_IMM)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_imm     (out_imm),
        .out_mode    (out_mode),
        .out_illegal (out_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic exp_t model(logic [31:0] ins);
        exp_t        e;
        logic [15:0] i16;
        int          s;
        i16   = ins[15:0];
        s     = int'($signed(i16));
        e.imm = 32'h0;
        e.mode = 3'd0;
        e.ill = 1'b0;
        case (ins[31:26])
            6'h0C, 6'h0D, 6'h0E: begin
                e.mode = 3'd1;
                e.imm  = 32'(i16);
            end
            6'h08, 6'h09, 6'h0A, 6'h0B,
            6'h20, 6'h23, 6'h24, 6'h28, 6'h2B: begin
                e.mode = 3'd2;
                e.imm  = s;
            end
            6'h0F: begin
                e.mode = 3'd3;
                e.imm  = 32'(i16) * 65536;
            end
            6'h01, 6'h04, 6'h05, 6'h06, 6'h07: begin
                e.mode = 3'd4;
                e.imm  = s * (1 << BR_SHIFT);
            end
            6'h02, 6'h03: begin
                e.mode = 3'd5;
                e.imm  = (ins % 32'h0400_0000) * 4;
            end
            6'h00: ;
            default: begin
                e.ill = 1'b1;
                e.imm = ILLEGAL_IMM;
            end
        endcase
        return e;
    endfunction

    // One handshake cycle: check occupancy, drive, update the scoreboard.
    task automatic cycle(logic iv, logic [31:0] ins,
                         logic ordy, logic fl);
        int occ;
        @(negedge clk);
        occ = sb.size();
        chk("out_valid_occ", 32'(out_valid), 32'(occ > 0));
        chk("in_ready_occ", 32'(in_ready), 32'(occ < 2));
        in_valid  = iv;
        in_instr  = ins;
        flush     = fl;
        out_ready = fl ? 1'b0 : ordy;
        #1;
        if (fl) sb.delete();
        else if (iv && occ < 2) sb.push_back(model(ins));
    endtask

    task automatic peek(string n, logic v, logic [31:0] imm,
                        logic [2:0] mode, logic ill);
        @(posedge clk);
        #1;
        chk({n, "_valid"}, 32'(out_valid), 32'(v));
        if (v) begin
            chk({n, "_imm"}, out_imm, imm);
            chk({n, "_mode"}, 32'(out_mode), 32'(mode));
            chk({n, "_ill"}, 32'(out_illegal), 32'(ill));
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: got %h want none",
                             out_imm);
                end else begin
                    e = sb.pop_front();
                    chk("sb_imm", out_imm, e.imm);
                    chk("sb_mode", 32'(out_mode), 32'(e.mode));
                    chk("sb_ill", 32'(out_illegal), 32'(e.ill));
                end
            end
        end
    end

    logic [5:0] legal_ops [20] = '{
        6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06,
        6'h07, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D,
        6'h0E, 6'h0F, 6'h20, 6'h23, 6'h28, 6'h2B
    };

    initial begin
        logic [31:0] r;
        logic [5:0]  op;

        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_imm", out_imm, 32'h0);
        chk("rst_mode", 32'(out_mode), 32'h0);
        chk("rst_ill", 32'(out_illegal), 32'h0);
        rst_n = 1'b1;

        cycle(1, 32'h3421_8001, 1, 0);
        peek("ori", 1, 32'h0000_8001, 3'd1, 0);
        cycle(1, 32'h2021_FFFE, 1, 0);
        peek("addi", 1, 32'hFFFF_FFFE, 3'd2, 0);
        cycle(1, 32'h3C01_1234, 1, 0);
        peek("lui", 1, 32'h1234_0000, 3'd3, 0);
        cycle(1, 32'h1021_8000, 1, 0);
        peek("beq", 1, 32'hFFFE_0000, 3'd4, 0);
        cycle(1, 32'h0800_0010, 1, 0);
        peek("j", 1, 32'h0000_0040, 3'd5, 0);
        cycle(0, 32'h0, 1, 0);

        cycle(1, 32'h3421_00AA, 0, 0);
        cycle(1, 32'h2021_8000, 0, 0);
        peek("stall", 1, 32'h0000_00AA, 3'd1, 0);
        chk("stall_in_ready", 32'(in_ready), 32'h0);
        cycle(1, 32'h3C01_5555, 0, 0);
        cycle(0, 32'h0, 1, 0);
        cycle(0, 32'h0, 1, 0);
        cycle(0, 32'h0, 0, 0);

        cycle(1, 32'h3421_0001, 0, 0);
        cycle(1, 32'h3421_0002, 0, 0);
        cycle(1, 32'h3421_0003, 1, 1);
        peek("flush_full", 0, 32'h0, 3'd0, 0);
        chk("flush_in_ready", 32'(in_ready), 32'h1);
        cycle(1, 32'h3421_0004, 0, 0);
        cycle(1, 32'h3421_0005, 0, 1);
        peek("flush_acc", 0, 32'h0, 3'd0, 0);
        cycle(0, 32'h0, 1, 0);

        cycle(1, 32'hFC00_1234, 1, 0);
        peek("illegal", 1, ILLEGAL_IMM, 3'd0, 1);
        cycle(0, 32'h0, 1, 0);

        cycle(1, 32'h3421_0777, 0, 0);
        cycle(1, 32'h3421_0888, 0, 0);
        @(negedge clk);
        in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'h0);
        chk("arst_in_ready", 32'(in_ready), 32'h1);
        chk("arst_imm", out_imm, 32'h0);
        sb.delete();
        @(negedge clk);
        #3;
        rst_n = 1'b1;

        for (int i = 0; i < 2000; i++) begin
            r = $urandom();
            if ($urandom_range(0, 9) < 8)
                op = legal_ops[$urandom_range(0, 19)];
            else
                op = 6'($urandom_range(0, 63));
            cycle(logic'($urandom_range(0, 9) < 7), {op, r[25:0]},
                  logic'($urandom_range(0, 9) < 7),
                  logic'($urandom_range(0, 31) == 0));
        end

        repeat (4) cycle(0, 32'h0, 1, 0);
        chk("drain_empty", 32'(sb.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
